mips_pipeline_hazard: RTL and testbench
=======================================

Name: mips_pipeline_hazard

Overview:
- Parametrised hazard and stall controller for the staged MIPS pipeline (pc -> reg -> ex -> mem).
- Keeps a scoreboard of in-flight register writes for STAGES post-decode stages and detects RAW hazards on the decode-stage operands.
- Drives PC/decode enables, bubble insertion, operand forwarding selects, branch squash and external freeze.
- Generalises the fixed four-stage arrangement to arbitrary depth, configurable load latency and delay-slot mode.

Parameters:
- STAGES, 3, post-decode stages tracked by the scoreboard (EX=0 .. STAGES-1); legal range 2..8.
- REG_W, 5, register index width.
- LOAD_LAT, 2, scoreboard index at which load results become forwardable; must be < STAGES.
- DELAYED, 1, 1 = branch delay slot executes; 0 = decode instruction is squashed on a taken branch.
- SEL_W, clog2(STAGES+1), forward-select width (derived).

Ports:
- clock  input  1  pipeline clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- id_valid  input  1  decode stage holds a real instruction.
- id_rs / id_rt  input  REG_W  decode source registers.
- id_rs_used / id_rt_used  input  1  source is actually read.
- id_wr  input  1  instruction writes a register.
- id_dst  input  REG_W  destination register.
- id_load  input  1  result is produced late (load).
- br_taken  input  1  taken branch/jump resolved this cycle.
- ext_stall  input  1  memory not ready; freeze whole pipeline.
- pc_en  output  1  PC may advance.
- id_en  output  1  pc/reg pipe register may load.
- ex_bubble  output  1  bubble injected into the reg/ex pipe this cycle.
- id_squash  output  1  decode instruction converted to NOP.
- fwd_rs_sel / fwd_rt_sel  output  SEL_W  0 = register file; k = result from scoreboard stage k-1.
- stage_valid  output  STAGES  per-stage valid from the scoreboard.
- stall_cnt  output  16  saturating count of hazard-stall cycles.

Behaviour:
- Scoreboard: STAGES entries {valid, wr, dst, load}. On advance, entry[0] <= issued decode instruction or bubble, and entry[i] <= entry[i-1]; the oldest entry retires.
- Entry i is ready when !load or i >= LOAD_LAT.
- Match for a source: used && src != 0 && entry.valid && entry.wr && entry.dst == src. The youngest (lowest-index) match wins; register 0 never matches.
- Hazard = any winning match not ready (without the forwarding feature, see below).
- FSM states:
  - RUN: no hazard, no ext_stall. pc_en=1, id_en=1; the scoreboard advances with the decode instruction.
  - HAZ: data hazard and !ext_stall. pc_en=0, id_en=0, ex_bubble=1; the scoreboard advances with a bubble in entry[0]; stall_cnt += 1, saturating at 0xFFFF. The FSM stays in HAZ until the hazard clears, with the decision re-evaluated combinationally every cycle.
  - FRZ: ext_stall=1, which has priority over everything. pc_en=0, id_en=0, ex_bubble=0; the scoreboard holds; stall_cnt holds. Return to RUN or HAZ the cycle after ext_stall drops.
- Branch handling:
  - br_taken in RUN with DELAYED=0: id_squash=1; the decode instruction enters the scoreboard as a bubble and no hazard is raised for it.
  - br_taken with DELAYED=1: the delay slot proceeds normally.
  - br_taken during HAZ or FRZ latches pend_br. pend_br applies (id_squash when DELAYED=0) on the first RUN cycle, then clears.
- Hazard and branch in the same cycle with DELAYED=0: the squash wins and there is no stall.
- Forward selects are valid only while id_en=1; otherwise they are driven to 0.
- Reset, asynchronous on reset_n low, including mid-stall:
  - all entries invalid, state RUN, pend_br=0, stall_cnt=0;
  - outputs after reset: pc_en=1, id_en=1, ex_bubble=0, id_squash=0, selects=0, stage_valid=0.
- Latency: a decision is combinational from the decode inputs and current scoreboard. The scoreboard update is visible on the next edge.

Optional Feature:
- Macro: MIPS_PIPELINE_HAZARD_FORWARD_EN.
- Defined:
  - fwd_*_sel = winning match index + 1 when that entry is ready, else 0;
  - only non-ready matches stall.
- Undefined:
  - fwd_*_sel tied to 0;
  - any winning match stalls (wait until the writer retires from the scoreboard);
  - LOAD_LAT is ignored.

Test Plan:
- Reset mid-HAZ with stall_cnt=5: assert reset_n=0 -> all outputs immediately at reset values; stall_cnt=0.
- With FORWARD_EN, back-to-back ALU ops: add r3 then sub r4,r3,r1 -> no stall; fwd_rs_sel=1. The next use of r3 one instruction later -> fwd_rs_sel=2.
- Load-use with LOAD_LAT=2: lw r5 then add r6,r5,r5 -> 2 HAZ cycles (ex_bubble=1, pc_en=0), then fwd_rs_sel=fwd_rt_sel=3; stall_cnt=2.
- Register 0: lw r0 then use r0 -> no stall, selects 0.
- ext_stall for 3 cycles during a load-use HAZ -> scoreboard frozen, stall_cnt unchanged during the freeze; total hazard stalls still 2.
- DELAYED=0, br_taken during HAZ -> pend_br=1; on the first RUN cycle id_squash=1 and entry[0] becomes a bubble. DELAYED=1, same stimulus -> no squash.

Source files
------------

// File: rtl/mips_pipeline_hazard.sv
// mips_pipeline_hazard
// Hazard and stall controller for the pc -> reg -> ex -> mem pipeline.
// A scoreboard of STAGES in-flight instructions (entry 0 = EX) is compared
// against the decode-stage source registers to detect RAW hazards. The block
// drives PC/decode enables, bubble insertion, operand forwarding selects,
// branch squash and a whole-pipeline freeze on ext_stall.
//
// Build option: define MIPS_PIPELINE_HAZARD_FORWARD_EN to enable operand
// forwarding from ready scoreboard entries. Without it, forwarding selects
// are tied to 0 and any matching in-flight writer stalls decode until that
// writer retires from the scoreboard.
//
// Handshake: there is no valid/ready pair. id_valid qualifies the decode
// inputs. An instruction is accepted on a rising clock edge exactly when
// id_en is high in that cycle. While id_en is low, the decode stage must hold
// its inputs stable.
//
// dbg_state reports the mode the controller took in the previous cycle:
// 0 = RUN, 1 = HAZ, 2 = FRZ.
module mips_pipeline_hazard #(
    parameter int STAGES   = 3,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 2,
    parameter int DELAYED  = 1,
    parameter int SEL_W    = $clog2(STAGES + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wr,
    input  logic [REG_W-1:0]  id_dst,
    input  logic              id_load,
    input  logic              br_taken,
    input  logic              ext_stall,
    output logic              pc_en,
    output logic              id_en,
    output logic              ex_bubble,
    output logic              id_squash,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic [STAGES-1:0] stage_valid,
    output logic [15:0]       stall_cnt,
    output logic [1:0]        dbg_state
);

`ifdef MIPS_PIPELINE_HAZARD_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_HAZ = 2'd1,
        ST_FRZ = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Scoreboard: entry 0 is the youngest (EX); entry STAGES-1 retires next.
    logic [STAGES-1:0]            sb_valid_q, sb_valid_d;
    logic [STAGES-1:0]            sb_wr_q,    sb_wr_d;
    logic [STAGES-1:0]            sb_load_q,  sb_load_d;
    logic [STAGES-1:0][REG_W-1:0] sb_dst_q,   sb_dst_d;

    logic        pend_br_q, pend_br_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Per-source winning match and its readiness.
    logic             rs_hit, rt_hit;
    logic [SEL_W-1:0] rs_idx, rt_idx;
    logic             rs_rdy, rt_rdy;
    logic             rs_stall, rt_stall, hazard;
    logic             squash_req, run;

    // Find the youngest in-flight writer of each decode source register.
    always_comb begin
        rs_hit = 1'b0;
        rs_idx = '0;
        rs_rdy = 1'b0;
        rt_hit = 1'b0;
        rt_idx = '0;
        rt_rdy = 1'b0;
        // Iterate oldest to youngest so the lowest-index match overwrites the others.
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (id_valid && id_rs_used && (id_rs != '0) && sb_valid_q[i] &&
                sb_wr_q[i] && (sb_dst_q[i] == id_rs)) begin
                rs_hit = 1'b1;
                rs_idx = SEL_W'(i);
                rs_rdy = !sb_load_q[i] || (i >= LOAD_LAT);
            end
            if (id_valid && id_rt_used && (id_rt != '0) && sb_valid_q[i] &&
                sb_wr_q[i] && (sb_dst_q[i] == id_rt)) begin
                rt_hit = 1'b1;
                rt_idx = SEL_W'(i);
                rt_rdy = !sb_load_q[i] || (i >= LOAD_LAT);
            end
        end
    end

    // Stall decision: without forwarding, any in-flight writer blocks the read.
    always_comb begin
        rs_stall = rs_hit && (!FWD_EN || !rs_rdy);
        rt_stall = rt_hit && (!FWD_EN || !rt_rdy);
        hazard   = rs_stall || rt_stall;
    end

    // Next-state and outputs: freeze beats squash, and squash beats a data stall.
    always_comb begin
        squash_req = (DELAYED == 0) && (br_taken || pend_br_q);
        state_d    = ST_RUN;
        if (ext_stall) begin
            state_d = ST_FRZ;
        end else if (hazard && !squash_req) begin
            state_d = ST_HAZ;
        end
        run        = (state_d == ST_RUN);
        pc_en      = run;
        id_en      = run;
        ex_bubble  = (state_d == ST_HAZ);
        id_squash  = run && squash_req;
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        if (FWD_EN && run && rs_hit && rs_rdy) begin
            fwd_rs_sel = rs_idx + SEL_W'(1);
        end
        if (FWD_EN && run && rt_hit && rt_rdy) begin
            fwd_rt_sel = rt_idx + SEL_W'(1);
        end
    end

    // A branch that arrives while decode is blocked is remembered for the first RUN cycle.
    always_comb begin
        pend_br_d = pend_br_q;
        if (state_d == ST_RUN) begin
            pend_br_d = 1'b0;
        end else if (br_taken) begin
            pend_br_d = 1'b1;
        end
    end

    // Hazard-stall counter, saturating; frozen cycles are not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_d == ST_HAZ) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Scoreboard shift: decode instruction or bubble enters entry 0 unless frozen.
    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_wr_d    = sb_wr_q;
        sb_load_d  = sb_load_q;
        sb_dst_d   = sb_dst_q;
        if (state_d != ST_FRZ) begin
            for (int i = STAGES - 1; i > 0; i--) begin
                sb_valid_d[i] = sb_valid_q[i-1];
                sb_wr_d[i]    = sb_wr_q[i-1];
                sb_load_d[i]  = sb_load_q[i-1];
                sb_dst_d[i]   = sb_dst_q[i-1];
            end
            if (state_d == ST_RUN) begin
                // A squashed delay-slot instruction travels as a bubble.
                sb_valid_d[0] = id_valid && !squash_req;
                sb_wr_d[0]    = id_wr;
                sb_load_d[0]  = id_load;
                sb_dst_d[0]   = id_dst;
            end else begin
                sb_valid_d[0] = 1'b0;
                sb_wr_d[0]    = 1'b0;
                sb_load_d[0]  = 1'b0;
                sb_dst_d[0]   = '0;
            end
        end
    end

    // State, scoreboard, pending-branch and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            sb_valid_q  <= '0;
            sb_wr_q     <= '0;
            sb_load_q   <= '0;
            sb_dst_q    <= '0;
            pend_br_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            sb_valid_q  <= sb_valid_d;
            sb_wr_q     <= sb_wr_d;
            sb_load_q   <= sb_load_d;
            sb_dst_q    <= sb_dst_d;
            pend_br_q   <= pend_br_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stage_valid = sb_valid_q;
    assign stall_cnt   = stall_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mips_pipeline_hazard.sv
// Bench for mips_pipeline_hazard. Two instances share the same stimulus:
// index 0 uses delay-slot mode and index 1 squashes the decode instruction
// on a taken branch. A history model of the last STAGES issued instructions
// predicts every output cycle by cycle. Directed scenarios come first,
// followed by a randomized stretch.
module tb_mips_pipeline_hazard;
    localparam int STAGES   = 3;
    localparam int REG_W    = 5;
    localparam int LOAD_LAT = 2;
    localparam int SEL_W    = $clog2(STAGES + 1);
`ifdef MIPS_PIPELINE_HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int M_RUN = 0;
    localparam int M_HAZ = 1;
    localparam int M_FRZ = 2;

    logic clock = 1'b0;
    logic reset_n;
    logic id_valid, id_rs_used, id_rt_used, id_wr, id_load, br_taken, ext_stall;
    logic [REG_W-1:0] id_rs, id_rt, id_dst;

    logic              pc_en_o  [2];
    logic              id_en_o  [2];
    logic              bub_o    [2];
    logic              sq_o     [2];
    logic [SEL_W-1:0]  rs_sel_o [2];
    logic [SEL_W-1:0]  rt_sel_o [2];
    logic [STAGES-1:0] sv_o     [2];
    logic [15:0]       cnt_o    [2];
    logic [1:0]        dbg_o    [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Clock and reset
    always #5 clock = ~clock;

    mips_pipeline_hazard #(.STAGES(STAGES), .REG_W(REG_W), .LOAD_LAT(LOAD_LAT), .DELAYED(1)) u_dly (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr), .id_dst(id_dst),
        .id_load(id_load), .br_taken(br_taken), .ext_stall(ext_stall),
        .pc_en(pc_en_o[0]), .id_en(id_en_o[0]), .ex_bubble(bub_o[0]), .id_squash(sq_o[0]),
        .fwd_rs_sel(rs_sel_o[0]), .fwd_rt_sel(rt_sel_o[0]), .stage_valid(sv_o[0]),
        .stall_cnt(cnt_o[0]), .dbg_state(dbg_o[0])
    );

    mips_pipeline_hazard #(.STAGES(STAGES), .REG_W(REG_W), .LOAD_LAT(LOAD_LAT), .DELAYED(0)) u_nod (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr), .id_dst(id_dst),
        .id_load(id_load), .br_taken(br_taken), .ext_stall(ext_stall),
        .pc_en(pc_en_o[1]), .id_en(id_en_o[1]), .ex_bubble(bub_o[1]), .id_squash(sq_o[1]),
        .fwd_rs_sel(rs_sel_o[1]), .fwd_rt_sel(rt_sel_o[1]), .stage_valid(sv_o[1]),
        .stall_cnt(cnt_o[1]), .dbg_state(dbg_o[1])
    );

    // Reference model: hist[k][a] is the instruction issued a advances ago.
    typedef struct packed {
        logic             v;
        logic             wr;
        logic [REG_W-1:0] dst;
        logic             ld;
    } rec_t;

    rec_t hist   [2][STAGES];
    int   m_cnt  [2];
    bit   m_pend [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < STAGES; a++) hist[k][a] = '0;
            m_cnt[k]  = 0;
            m_pend[k] = 1'b0;
        end
    endtask

    function automatic int writer_age(input int k, input logic used, input logic [REG_W-1:0] src);
        if (!id_valid || !used || src == '0) return -1;
        for (int a = 0; a < STAGES; a++) begin
            if (hist[k][a].v && hist[k][a].wr && hist[k][a].dst == src) return a;
        end
        return -1;
    endfunction

    function automatic bit is_ready(input int k, input int age);
        if (age < 0) return 1'b0;
        return !hist[k][age].ld || age >= LOAD_LAT;
    endfunction

    function automatic void eval(input int k, output int mode, output bit sq,
                                 output int rs_sel, output int rt_sel);
        int ars, art;
        bit rdy_s, rdy_t, haz, sq_req;
        ars    = writer_age(k, id_rs_used, id_rs);
        art    = writer_age(k, id_rt_used, id_rt);
        rdy_s  = is_ready(k, ars);
        rdy_t  = is_ready(k, art);
        haz    = FWD ? ((ars >= 0 && !rdy_s) || (art >= 0 && !rdy_t)) : (ars >= 0 || art >= 0);
        sq_req = (k == 1) && (br_taken || m_pend[k]);
        if (ext_stall) mode = M_FRZ;
        else if (haz && !sq_req) mode = M_HAZ;
        else mode = M_RUN;
        sq     = (mode == M_RUN) && sq_req;
        rs_sel = (FWD && mode == M_RUN && rdy_s) ? ars + 1 : 0;
        rt_sel = (FWD && mode == M_RUN && rdy_t) ? art + 1 : 0;
    endfunction

    // Driver tasks
    task automatic set_in(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                          input bit wr, input int dst, input bit ld);
        id_valid   = v;
        id_rs      = REG_W'(rs);
        id_rt      = REG_W'(rt);
        id_rs_used = rsu;
        id_rt_used = rtu;
        id_wr      = wr;
        id_dst     = REG_W'(dst);
        id_load    = ld;
        br_taken   = 1'b0;
        ext_stall  = 1'b0;
    endtask

    task automatic idle();
        set_in(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic check_now();
        int mode, rs, rt;
        bit sq;
        logic [STAGES-1:0] sv;
        #1;
        for (int k = 0; k < 2; k++) begin
            eval(k, mode, sq, rs, rt);
            for (int a = 0; a < STAGES; a++) sv[a] = hist[k][a].v;
            chk($sformatf("pc_en[%0d]", k), 32'(pc_en_o[k]), 32'(mode == M_RUN));
            chk($sformatf("id_en[%0d]", k), 32'(id_en_o[k]), 32'(mode == M_RUN));
            chk($sformatf("ex_bubble[%0d]", k), 32'(bub_o[k]), 32'(mode == M_HAZ));
            chk($sformatf("id_squash[%0d]", k), 32'(sq_o[k]), 32'(sq));
            chk($sformatf("fwd_rs_sel[%0d]", k), 32'(rs_sel_o[k]), rs);
            chk($sformatf("fwd_rt_sel[%0d]", k), 32'(rt_sel_o[k]), rt);
            chk($sformatf("stage_valid[%0d]", k), 32'(sv_o[k]), 32'(sv));
            chk($sformatf("stall_cnt[%0d]", k), 32'(cnt_o[k]), m_cnt[k]);
        end
    endtask

    task automatic advance();
        int mode, rs, rt;
        bit sq;
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            eval(k, mode, sq, rs, rt);
            if (mode != M_FRZ) begin
                for (int a = STAGES - 1; a > 0; a--) hist[k][a] = hist[k][a-1];
                if (mode == M_RUN)
                    hist[k][0] = '{v: id_valid && !sq, wr: id_wr, dst: id_dst, ld: id_load};
                else
                    hist[k][0] = '0;
            end
            if (mode == M_HAZ && m_cnt[k] < 65535) m_cnt[k]++;
            if (mode == M_RUN) m_pend[k] = 1'b0;
            else if (br_taken) m_pend[k] = 1'b1;
        end
        @(negedge clock);
    endtask

    task automatic step();
        check_now();
        advance();
    endtask

    // Present one instruction until instance 0 accepts it; report stalls and selects seen.
    task automatic issue(input string tag, input bit v, input int rs, input int rt, input bit rsu,
                         input bit rtu, input bit wr, input int dst, input bit ld,
                         output int n_stall, output logic [SEL_W-1:0] acc_rs,
                         output logic [SEL_W-1:0] acc_rt);
        int mode, r1, r2;
        bit sq, done;
        set_in(v, rs, rt, rsu, rtu, wr, dst, ld);
        n_stall = 0;
        done    = 1'b0;
        acc_rs  = '0;
        acc_rt  = '0;
        for (int n = 0; n < 20 && !done; n++) begin
            eval(0, mode, sq, r1, r2);
            check_now();
            if (id_en_o[0] !== 1'b1) begin
                n_stall++;
            end else begin
                acc_rs = rs_sel_o[0];
                acc_rt = rt_sel_o[0];
            end
            done = (mode == M_RUN);
            advance();
        end
        chk({tag, "_accepted"}, 32'(done), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns, mode, r1, r2, c0, which;
        bit sq, hit;
        logic [SEL_W-1:0] ars, art;

        reset_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clock);
        check_now();
        reset_n = 1'b1;
        @(negedge clock);

        // Reset asserted in the middle of a load-use stall once stall_cnt reaches 5.
        hit   = 1'b0;
        which = 0;
        for (int n = 0; n < 60 && !hit; n++) begin
            if (which == 0) set_in(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b1);
            else            set_in(1'b1, 5, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0);
            eval(0, mode, sq, r1, r2);
            check_now();
            if (mode == M_HAZ && m_cnt[0] == 5) begin
                hit = 1'b1;
            end else begin
                advance();
                if (mode == M_RUN) which = 1 - which;
            end
        end
        chk("midhaz_reached", 32'(hit), 1);
        chk("midhaz_cnt", 32'(cnt_o[0]), 5);
        chk("midhaz_bubble", 32'(bub_o[0]), 1);
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_pc_en%0d", k), 32'(pc_en_o[k]), 1);
            chk($sformatf("rst_id_en%0d", k), 32'(id_en_o[k]), 1);
            chk($sformatf("rst_bubble%0d", k), 32'(bub_o[k]), 0);
            chk($sformatf("rst_squash%0d", k), 32'(sq_o[k]), 0);
            chk($sformatf("rst_rs_sel%0d", k), 32'(rs_sel_o[k]), 0);
            chk($sformatf("rst_rt_sel%0d", k), 32'(rt_sel_o[k]), 0);
            chk($sformatf("rst_stage_valid%0d", k), 32'(sv_o[k]), 0);
            chk($sformatf("rst_stall_cnt%0d", k), 32'(cnt_o[k]), 0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        idle();
        step();

        // Back-to-back ALU ops: add r3 ; sub r4,r3,r1 ; and r8,r3,r4
        issue("alu_add", 1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 3, 1'b0, ns, ars, art);
        chk("alu_add_stalls", ns, 0);
        issue("alu_sub", 1'b1, 3, 1, 1'b1, 1'b1, 1'b1, 4, 1'b0, ns, ars, art);
        chk("b2b_stalls", ns, FWD ? 0 : 3);
        chk("b2b_rs_sel", 32'(ars), FWD ? 1 : 0);
        issue("alu_and", 1'b1, 3, 4, 1'b1, 1'b1, 1'b1, 8, 1'b0, ns, ars, art);
        chk("gap1_stalls", ns, FWD ? 0 : 3);
        chk("gap1_rs_sel", 32'(ars), FWD ? 2 : 0);
        chk("gap1_rt_sel", 32'(art), FWD ? 1 : 0);

        // Load-use: lw r5 ; add r6,r5,r5
        c0 = int'(cnt_o[0]);
        issue("lu_lw", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b1, ns, ars, art);
        issue("lu_add", 1'b1, 5, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0, ns, ars, art);
        chk("lu_stalls", ns, FWD ? 2 : 3);
        chk("lu_rs_sel", 32'(ars), FWD ? 3 : 0);
        chk("lu_rt_sel", 32'(art), FWD ? 3 : 0);
        chk("lu_cnt_delta", int'(cnt_o[0]) - c0, FWD ? 2 : 3);

        // Register 0 never matches: lw r0 ; add r7,r0,r0
        issue("r0_lw", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b1, ns, ars, art);
        issue("r0_add", 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 7, 1'b0, ns, ars, art);
        chk("r0_stalls", ns, 0);
        chk("r0_rs_sel", 32'(ars), 0);
        chk("r0_rt_sel", 32'(art), 0);

        // Freeze for 3 cycles in the middle of a load-use stall.
        c0 = int'(cnt_o[0]);
        issue("frz_lw", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b1, ns, ars, art);
        set_in(1'b1, 5, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0);
        step();
        ext_stall = 1'b1;
        for (int n = 0; n < 3; n++) begin
            check_now();
            chk("frz_stage_valid", 32'(sv_o[0]), 32'b110);
            chk("frz_cnt", int'(cnt_o[0]) - c0, 1);
            chk("frz_pc_en", 32'(pc_en_o[0]), 0);
            chk("frz_bubble", 32'(bub_o[0]), 0);
            advance();
        end
        issue("frz_add", 1'b1, 5, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0, ns, ars, art);
        chk("frz_total_stalls", int'(cnt_o[0]) - c0, FWD ? 2 : 3);

        // Taken branch while a load-use stall is in progress.
        issue("brh_lw", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b1, ns, ars, art);
        set_in(1'b1, 5, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0);
        step();
        br_taken = 1'b1;
        check_now();
        chk("brh_squash_nod", 32'(sq_o[1]), 1);
        chk("brh_id_en_nod", 32'(id_en_o[1]), 1);
        chk("brh_bubble_nod", 32'(bub_o[1]), 0);
        chk("brh_squash_dly", 32'(sq_o[0]), 0);
        chk("brh_bubble_dly", 32'(bub_o[0]), 1);
        advance();
        chk("brh_slot_bubble_nod", 32'(sv_o[1][0]), 0);
        idle();
        repeat (STAGES + 1) step();

        // Taken branch during a freeze applies on the first RUN cycle.
        issue("brf_lw", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b1, ns, ars, art);
        set_in(1'b1, 5, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0);
        ext_stall = 1'b1;
        br_taken  = 1'b1;
        step();
        ext_stall = 1'b0;
        br_taken  = 1'b0;
        check_now();
        chk("brf_squash_nod", 32'(sq_o[1]), 1);
        chk("brf_squash_dly", 32'(sq_o[0]), 0);
        chk("brf_bubble_dly", 32'(bub_o[0]), 1);
        advance();
        chk("brf_slot_bubble_nod", 32'(sv_o[1][0]), 0);
        idle();
        repeat (STAGES + 1) step();

        // Randomized stretch against the model.
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 2) == 0);
            br_taken  = ($urandom_range(0, 9) == 0);
            ext_stall = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
